decoder_scoreboard: RTL and testbench
=====================================

// Module: decoder_scoreboard
// PURPOSE
//  Parametrised successor to the 5-to-32 combinational decoder: decodes an ADDR_W-bit register
//  index to a 2**ADDR_W one-hot vector, registered, and uses the same decode to track pending writes.
//  Sits between control/issue and the register file.
//  - Drives the register-file write-enable lines.
//  - Produces the read-after-write stall and the write-after-write issue back-pressure.
// PARAMETERS
//  ADDR_W     5  register index width; DEPTH = 2**ADDR_W entries
//  ZERO_HARD  1  1: index 0 is hardwired zero, never decoded, never pending
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         synchronous, active-high reset
//  issue_valid  in   1         issuing instruction has a destination register
//  issue_rd     in   ADDR_W    destination index of the issuing instruction
//  issue_ready  out  1         issue accepted this cycle when issue_valid && issue_ready
//  wb_valid     in   1         writeback occurring this cycle
//  wb_rd        in   ADDR_W    writeback destination index
//  rs, rt       in   ADDR_W    source indices of the instruction in decode
//  stall        out  1         a source has a pending write; combinational
//  we_onehot    out  2**ADDR_W registered one-hot register-file write enables
//  pending      out  2**ADDR_W registered pending-write bit per register
//  err          out  1         sticky: writeback to a non-pending register
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): we_onehot=0, pending=0, err=0. Takes priority over all
//    inputs, including mid-operation; in-flight writes are forgotten.
//  - dec(x) = 1<<x. If ZERO_HARD=1 and x==0, dec(x)=0. Indices are unsigned; no out-of-range
//    values exist (DEPTH = 2**ADDR_W).
//  - we_onehot, 1-cycle latency: next = wb_valid ? dec(wb_rd) : 0.
//    At most one bit is set. we_onehot is all-zero when idle.
//  - issue_ready = ~pending[issue_rd] | (wb_valid & wb_rd==issue_rd) | (ZERO_HARD & issue_rd==0).
//    Combinational. WAW on a still-pending register is back-pressured.
//  - Accept: acc = issue_valid & issue_ready.
//  - pending update, each edge:
//      pending_next = (pending & ~(wb_valid ? dec(wb_rd) : 0)) | (acc ? dec(issue_rd) : 0)
//  - Simultaneous wb and accepted issue to the same rd: the set wins, so the bit stays 1
//    (the new writer owns it).
//  - Simultaneous wb and issue to different rd: both apply in the same cycle.
//  - stall = pending[rs] | pending[rt]. Uses registered pending only.
//  - Same-cycle writeback does NOT clear the stall: the register file writes on the edge, so the
//    stall releases the next cycle. No bypass.
//  - With ZERO_HARD=1, rs/rt == 0 never stall.
//  - err: set on an edge when wb_valid & ~pending[wb_rd] & ~(ZERO_HARD & wb_rd==0). Held until rst.
//    we_onehot is still driven for that writeback.
//  - No FSM beyond the pending vector and err; all state is flops on clk.
// TESTING
//  1 Reset: drive rst 1 cycle with random inputs -> we_onehot=0, pending=0, err=0 the next cycle.
//  2 Issue rd=7, then rs=7 -> stall=1.
//    Next cycle wb rd=7 -> we_onehot=32'h80, pending[7]=0, stall=0 one cycle after wb.
//  3 pending[9]=1, issue rd=9 with no wb -> issue_ready=0, pending unchanged.
//    Same issue with wb_rd=9 -> issue_ready=1, pending[9] stays 1, we_onehot=32'h200.
//  4 ZERO_HARD=1: issue rd=0 and wb rd=0 -> issue_ready=1, pending=0, we_onehot=0, err=0,
//    and rs=0 gives stall=0.
//  5 wb rd=3 with pending[3]=0 -> err=1 and stays 1 after further traffic.
//    rst -> err=0.
//  6 ADDR_W=3 sweep: wb every index 0..7 -> we_onehot = 1<<i, with bit 0 never set when ZERO_HARD=1.

Source files
------------

// File: rtl/decoder_scoreboard.sv
// Register-index decoder with registered write enables and a pending-write
// scoreboard that produces RAW stalls and WAW issue back-pressure.
module decoder_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter bit ZERO_HARD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [ADDR_W-1:0]        rs,
  input  logic [ADDR_W-1:0]        rt,
  output logic                     stall,
  output logic [(1<<ADDR_W)-1:0]   we_onehot,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     err
);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [DEPTH-1:0] dec(
    input logic [ADDR_W-1:0] x
  );
    logic [DEPTH-1:0] r;
    r = '0;
    if (!(ZERO_HARD && x == '0))
      r[x] = 1'b1;
    return r;
  endfunction

  logic [DEPTH-1:0] we_q, we_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [DEPTH-1:0] wb_dec, iss_dec;
  logic             err_q, err_d;
  logic             acc;
  logic             wb_zero, iss_zero;

  assign wb_zero  = ZERO_HARD && (wb_rd == '0);
  assign iss_zero = ZERO_HARD && (issue_rd == '0);

  // A same-cycle writeback to the target frees it for the new writer.
  assign issue_ready = ~pend_q[issue_rd]
                     | (wb_valid & (wb_rd == issue_rd))
                     | iss_zero;

  assign acc   = issue_valid & issue_ready;
  assign stall = pend_q[rs] | pend_q[rt];

  always_comb begin
    wb_dec  = wb_valid ? dec(wb_rd) : '0;
    iss_dec = acc ? dec(issue_rd) : '0;
    we_d    = wb_dec;
    // Set after clear: a new writer keeps ownership of the bit.
    pend_d  = (pend_q & ~wb_dec) | iss_dec;
    err_d   = err_q
            | (wb_valid & ~pend_q[wb_rd] & ~wb_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign we_onehot = we_q;
  assign pending   = pend_q;
  assign err       = err_q;

endmodule

// File: tb/tb_decoder_scoreboard.sv
// Bench for decoder_scoreboard: directed vector table, reset checks,
// a 3-bit index sweep, and random traffic against a scoreboard model.
module tb_decoder_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, wb_valid;
  logic [4:0]  issue_rd, wb_rd, rs, rt;
  logic        issue_ready, stall, err;
  logic [31:0] we_onehot, pending;

  logic        iv_s, wv_s;
  logic [2:0]  ird_s, wrd_s, rs_s, rt_s;
  logic        rdy_s, stall_s, err_s;
  logic [7:0]  we_s, pend_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_scoreboard #(.ADDR_W(5), .ZERO_HARD(1'b1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .rs(rs), .rt(rt), .stall(stall),
    .we_onehot(we_onehot), .pending(pending), .err(err)
  );

  decoder_scoreboard #(.ADDR_W(3), .ZERO_HARD(1'b1)) dut_s (
    .clk(clk), .rst(rst),
    .issue_valid(iv_s), .issue_rd(ird_s),
    .issue_ready(rdy_s),
    .wb_valid(wv_s), .wb_rd(wrd_s),
    .rs(rs_s), .rt(rt_s), .stall(stall_s),
    .we_onehot(we_s), .pending(pend_s), .err(err_s)
  );

  typedef struct {
    bit        iv;
    int        ird;
    bit        wv;
    int        wrd;
    int        rs;
    int        rt;
    bit        e_ready;
    bit        e_stall;
    logic [31:0] e_we;
    logic [31:0] e_pend;
    bit        e_err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit iv, input int ird,
                       input bit wv, input int wrd,
                       input int a, input int b);
    issue_valid = iv;
    issue_rd    = 5'(ird);
    wb_valid    = wv;
    wb_rd       = 5'(wrd);
    rs          = 5'(a);
    rt          = 5'(b);
  endtask

  // model state
  bit pend_m[32];
  bit err_m;

  initial begin
    // idx: iv ird wv wrd rs rt | ready stall | we pend err
    vt[0]  = '{1, 7, 0, 0, 7, 0, 1, 0, 32'h0,   32'h80,  0};
    vt[1]  = '{0, 0, 1, 7, 7, 0, 1, 1, 32'h80,  32'h0,   0};
    vt[2]  = '{0, 0, 0, 0, 7, 0, 1, 0, 32'h0,   32'h0,   0};
    vt[3]  = '{1, 9, 0, 0, 9, 0, 1, 0, 32'h0,   32'h200, 0};
    vt[4]  = '{1, 9, 0, 0, 9, 0, 0, 1, 32'h0,   32'h200, 0};
    vt[5]  = '{1, 9, 1, 9, 9, 0, 1, 1, 32'h200, 32'h200, 0};
    vt[6]  = '{1, 0, 1, 0, 0, 0, 1, 0, 32'h0,   32'h200, 0};
    vt[7]  = '{0, 0, 1, 9, 0, 0, 1, 0, 32'h200, 32'h0,   0};
    vt[8]  = '{0, 0, 1, 3, 0, 0, 1, 0, 32'h8,   32'h0,   1};
    vt[9]  = '{1, 5, 0, 0, 0, 5, 1, 0, 32'h0,   32'h20,  1};
    vt[10] = '{1, 6, 1, 5, 0, 5, 1, 1, 32'h20,  32'h40,  1};

    iv_s = 0; wv_s = 0; ird_s = '0; wrd_s = '0;
    rs_s = '0; rt_s = '0;

    // reset with random inputs applied
    @(negedge clk);
    rst = 1'b1;
    drive(1'($urandom), int'($urandom_range(0, 31)),
          1'($urandom), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)));
    @(posedge clk); #1;
    chk("rst_we", we_onehot, 32'h0);
    chk("rst_pend", pending, 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].iv, vt[i].ird, vt[i].wv,
            vt[i].wrd, vt[i].rs, vt[i].rt);
      #1;
      chk($sformatf("v%0d_ready", i),
          32'(issue_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d_stall", i),
          32'(stall), 32'(vt[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), we_onehot, vt[i].e_we);
      chk($sformatf("v%0d_pend", i), pending, vt[i].e_pend);
      chk($sformatf("v%0d_err", i),
          32'(err), 32'(vt[i].e_err));
      @(negedge clk);
    end

    // sticky err survives more traffic, then reset clears it
    drive(0, 0, 1, 6, 6, 0);
    #1;
    chk("seq_stall6", 32'(stall), 32'h1);
    @(posedge clk); #1;
    chk("seq_err_hold", 32'(err), 32'h1);
    chk("seq_pend_clr", pending, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 12, 1, 4, 0, 0);
    @(posedge clk); #1;
    chk("seq_rst_err", 32'(err), 32'h0);
    chk("seq_rst_pend", pending, 32'h0);
    chk("seq_rst_we", we_onehot, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // 3-bit sweep on the small instance
    for (int i = 0; i < 8; i++) begin
      wv_s  = 1'b1;
      wrd_s = 3'(i);
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_we", i), 32'(we_s),
          (i == 0) ? 32'h0 : (32'h1 << i));
      @(negedge clk);
    end
    wv_s = 1'b0;
    @(posedge clk); #1;
    chk("sweep_idle_we", 32'(we_s), 32'h0);
    @(negedge clk);

    // random traffic vs model (pending is clear, err is clear)
    foreach (pend_m[k]) pend_m[k] = 1'b0;
    err_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit iv, wv, rr, e_rdy, e_st, acc;
      int ird, wrd, a, b;
      logic [31:0] e_we, e_pend;
      rr  = ($urandom_range(0, 63) == 0);
      iv  = 1'($urandom);
      wv  = 1'($urandom);
      ird = ($urandom % 2) ? int'($urandom_range(0, 7))
                           : int'($urandom_range(0, 31));
      wrd = ($urandom % 2) ? int'($urandom_range(0, 7))
                           : int'($urandom_range(0, 31));
      a   = int'($urandom_range(0, 9));
      b   = int'($urandom_range(0, 31));
      rst = rr;
      drive(iv, ird, wv, wrd, a, b);
      e_rdy = !pend_m[ird] || (wv && wrd == ird) || ird == 0;
      e_st  = pend_m[a] || pend_m[b];
      #1;
      chk($sformatf("r%0d_ready", c), 32'(issue_ready), 32'(e_rdy));
      chk($sformatf("r%0d_stall", c), 32'(stall), 32'(e_st));
      acc = iv && e_rdy;
      if (rr) begin
        foreach (pend_m[k]) pend_m[k] = 1'b0;
        err_m = 1'b0;
        e_we  = 32'h0;
      end else begin
        if (wv && wrd != 0 && !pend_m[wrd]) err_m = 1'b1;
        e_we = (wv && wrd != 0) ? (32'h1 << wrd) : 32'h0;
        if (wv) pend_m[wrd] = 1'b0;
        if (acc) pend_m[ird] = 1'b1;
        pend_m[0] = 1'b0;
      end
      e_pend = '0;
      for (int k = 0; k < 32; k++) e_pend[k] = pend_m[k];
      @(posedge clk); #1;
      chk($sformatf("r%0d_we", c), we_onehot, e_we);
      chk($sformatf("r%0d_pend", c), pending, e_pend);
      chk($sformatf("r%0d_err", c), 32'(err), 32'(err_m));
      @(negedge clk);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
